vga_timing_gen: RTL and testbench

- Parametrised, runtime-reconfigurable VGA/VESA raster timing generator.
- Successor to the fixed 10-bit sync generator.
- Adds generic counter width, a pixel clock-enable, a four-segment timing model per axis, and per-axis sync polarity.
- Timing changes are staged and applied only at frame boundaries. Output feeds the colour/pattern stage of the display pipeline.

---
 rtl/vga_timing_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-reconfigurable VGA/VESA raster timing generator.
// Each axis runs active -> front porch -> sync -> back porch. New timing is
// staged by cfg_wr and takes effect only at the next frame boundary.
// Optional feature macro: VGA_FRAME_CNT_EN (enables the 16-bit frame counter).
module vga_timing_gen #(
    parameter int unsigned CW      = 12,
    parameter int unsigned H_ACT_D = 640,
    parameter int unsigned H_FP_D  = 16,
    parameter int unsigned H_SYN_D = 96,
    parameter int unsigned H_BP_D  = 48,
    parameter int unsigned V_ACT_D = 480,
    parameter int unsigned V_FP_D  = 10,
    parameter int unsigned V_SYN_D = 2,
    parameter int unsigned V_BP_D  = 33,
    parameter bit          HPOL_D  = 1'b0,
    parameter bit          VPOL_D  = 1'b0
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          pix_ce,
    input  logic          cfg_wr,
    input  logic [CW-1:0] cfg_h_act,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_syn,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_act,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_syn,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic          hsync,
    output logic          vsync,
    output logic          vidon,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    // Totals need two extra bits so four CW-wide segments never overflow.
    localparam int unsigned TW = CW + 2;
    localparam logic [TW-1:0] TOT_MAX = TW'(1) << CW;

    typedef struct packed {
        logic [CW-1:0] h_act;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_syn;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_act;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_syn;
        logic [CW-1:0] v_bp;
        logic          hpol;
        logic          vpol;
    } tcfg_t;

    localparam tcfg_t CFG_RST = '{
        h_act: CW'(H_ACT_D),
        h_fp:  CW'(H_FP_D),
        h_syn: CW'(H_SYN_D),
        h_bp:  CW'(H_BP_D),
        v_act: CW'(V_ACT_D),
        v_fp:  CW'(V_FP_D),
        v_syn: CW'(V_SYN_D),
        v_bp:  CW'(V_BP_D),
        hpol:  HPOL_D,
        vpol:  VPOL_D
    };

    // State registers
    logic [CW-1:0] h_q, v_q;
    tcfg_t         live_q, stage_q;

    // Next-state values
    logic [CW-1:0] h_n, v_n;
    tcfg_t         live_n, stage_n;
    logic          pend_n, err_n;
    logic          hsync_n, vsync_n, vidon_n, ls_n, fs_n;
    logic [CW-1:0] hc_n, vc_n;

    // Candidate config and its validity
    tcfg_t         cfg_in;
    logic [TW-1:0] h_tot_in, v_tot_in;
    logic          cfg_ok;

    // Decode helpers derived from the live timing
    logic [TW-1:0] h_tot, v_tot, hs_beg, hs_end, vs_beg, vs_end;
    logic [CW-1:0] h_last, v_last;
    logic          h_end, v_end, frame_end;
    logic          hs_act, vs_act;

    // Validate the incoming config write
    always_comb begin
        cfg_in = '{
            h_act: cfg_h_act, h_fp: cfg_h_fp, h_syn: cfg_h_syn, h_bp: cfg_h_bp,
            v_act: cfg_v_act, v_fp: cfg_v_fp, v_syn: cfg_v_syn, v_bp: cfg_v_bp,
            hpol:  cfg_hpol,  vpol: cfg_vpol
        };
        h_tot_in = TW'(cfg_h_act) + TW'(cfg_h_fp) + TW'(cfg_h_syn) + TW'(cfg_h_bp);
        v_tot_in = TW'(cfg_v_act) + TW'(cfg_v_fp) + TW'(cfg_v_syn) + TW'(cfg_v_bp);
        cfg_ok   = (cfg_h_act != '0) && (cfg_h_fp != '0) && (cfg_h_syn != '0) &&
                   (cfg_h_bp != '0)  && (cfg_v_act != '0) && (cfg_v_fp != '0) &&
                   (cfg_v_syn != '0) && (cfg_v_bp != '0) &&
                   (h_tot_in <= TOT_MAX) && (v_tot_in <= TOT_MAX);
    end

    // Segment boundaries and wrap points of the live timing
    always_comb begin
        h_tot     = TW'(live_q.h_act) + TW'(live_q.h_fp) + TW'(live_q.h_syn) + TW'(live_q.h_bp);
        v_tot     = TW'(live_q.v_act) + TW'(live_q.v_fp) + TW'(live_q.v_syn) + TW'(live_q.v_bp);
        hs_beg    = TW'(live_q.h_act) + TW'(live_q.h_fp);
        hs_end    = hs_beg + TW'(live_q.h_syn);
        vs_beg    = TW'(live_q.v_act) + TW'(live_q.v_fp);
        vs_end    = vs_beg + TW'(live_q.v_syn);
        h_last    = CW'(h_tot - TW'(1));
        v_last    = CW'(v_tot - TW'(1));
        h_end     = (h_q == h_last);
        v_end     = (v_q == v_last);
        frame_end = pix_ce && h_end && v_end;
        hs_act    = (TW'(h_q) >= hs_beg) && (TW'(h_q) < hs_end);
        vs_act    = (TW'(v_q) >= vs_beg) && (TW'(v_q) < vs_end);
    end

    // Next-state: counters, output decode, config staging and apply
    always_comb begin
        h_n     = h_q;
        v_n     = v_q;
        live_n  = live_q;
        stage_n = stage_q;
        pend_n  = cfg_pending;
        err_n   = cfg_err;
        hc_n    = hc;
        vc_n    = vc;
        hsync_n = hsync;
        vsync_n = vsync;
        vidon_n = vidon;
        ls_n    = 1'b0;
        fs_n    = 1'b0;

        if (pix_ce) begin
            h_n     = h_end ? '0 : h_q + CW'(1);
            if (h_end) begin
                v_n = v_end ? '0 : v_q + CW'(1);
            end
            hc_n    = h_q;
            vc_n    = v_q;
            hsync_n = hs_act ? live_q.hpol : ~live_q.hpol;
            vsync_n = vs_act ? live_q.vpol : ~live_q.vpol;
            vidon_n = (h_q < live_q.h_act) && (v_q < live_q.v_act);
            ls_n    = (h_q == '0);
            fs_n    = (h_q == '0) && (v_q == '0);
        end

        // Apply before capture so a same-cycle write lands only in staging
        if (frame_end && cfg_pending) begin
            live_n = stage_q;
            pend_n = 1'b0;
        end

        if (cfg_wr) begin
            if (cfg_ok) begin
                stage_n = cfg_in;
                pend_n  = 1'b1;
                err_n   = 1'b0;
            end else begin
                err_n   = 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            h_q         <= '0;
            v_q         <= '0;
            live_q      <= CFG_RST;
            stage_q     <= CFG_RST;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            hsync       <= ~HPOL_D;
            vsync       <= ~VPOL_D;
            vidon       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_q         <= h_n;
            v_q         <= v_n;
            live_q      <= live_n;
            stage_q     <= stage_n;
            cfg_pending <= pend_n;
            cfg_err     <= err_n;
            hc          <= hc_n;
            vc          <= vc_n;
            hsync       <= hsync_n;
            vsync       <= vsync_n;
            vidon       <= vidon_n;
            line_start  <= ls_n;
            frame_start <= fs_n;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt_q;

    // Count frames in step with the frame_start pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            fcnt_q <= '0;
        end else if (fs_n) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800-clk lines with a short
// 10-line frame, pix_ce halving, staged reconfiguration and rejection cases.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        clr, pix_ce, cfg_wr;
    logic [11:0] cfg_h_act, cfg_h_fp, cfg_h_syn, cfg_h_bp;
    logic [11:0] cfg_v_act, cfg_v_fp, cfg_v_syn, cfg_v_bp;
    logic        cfg_hpol, cfg_vpol;
    logic        cfg_pending, cfg_err, hsync, vsync, vidon, line_start, frame_start;
    logic [11:0] hc, vc;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cur    = -1;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CW(12), .H_ACT_D(640), .H_FP_D(16), .H_SYN_D(96), .H_BP_D(48),
        .V_ACT_D(4), .V_FP_D(2), .V_SYN_D(1), .V_BP_D(3),
        .HPOL_D(1'b0), .VPOL_D(1'b0)
    ) dut (
        .clk(clk), .clr(clr), .pix_ce(pix_ce), .cfg_wr(cfg_wr),
        .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_syn(cfg_h_syn), .cfg_h_bp(cfg_h_bp),
        .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_syn(cfg_v_syn), .cfg_v_bp(cfg_v_bp),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .hsync(hsync), .vsync(vsync), .vidon(vidon), .hc(hc), .vc(vc),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    typedef struct {
        int          pos;
        logic [11:0] hc, vc;
        logic        hs, vs, vid, ls, fs;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [11:0] e_hc, input logic [11:0] e_vc,
                           input logic e_hs, input logic e_vs, input logic e_vid,
                           input logic e_ls, input logic e_fs);
        chk(nm, {hc, vc, hsync, vsync, vidon, line_start, frame_start},
                {e_hc, e_vc, e_hs, e_vs, e_vid, e_ls, e_fs});
    endtask

    task automatic chk_pe(input string nm, input logic e_pend, input logic e_err);
        chk(nm, {cfg_pending, cfg_err}, {e_pend, e_err});
    endtask

    // Advance with pix_ce=1 until the outputs show raster position p
    task automatic goto(input int p);
        while (cur < p) begin
            step(1);
            cur++;
        end
    endtask

    task automatic wr(input logic [11:0] ha, hf, hs, hb, va, vf, vs, vb,
                      input logic hp, vp);
        cfg_h_act = ha; cfg_h_fp = hf; cfg_h_syn = hs; cfg_h_bp = hb;
        cfg_v_act = va; cfg_v_fp = vf; cfg_v_syn = vs; cfg_v_bp = vb;
        cfg_hpol = hp;  cfg_vpol = vp;
        cfg_wr = 1'b1;
        step(1);
        cur++;
        cfg_wr = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        cur = -1;
    endtask

    vec_t vt[18];

    initial begin
        int bad, en_cnt;
        logic [11:0] prev_hc, e_hc, e_vc;
        int ls_t[$];

        // Default timing: 640/16/96/48 x 4/2/1/3, sync active-low
        vt[0]  = '{0,    12'd0,   12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[1]  = '{1,    12'd1,   12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{639,  12'd639, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{640,  12'd640, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{655,  12'd655, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{656,  12'd656, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{751,  12'd751, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{752,  12'd752, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{799,  12'd799, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{800,  12'd0,   12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{3039, 12'd639, 12'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{3200, 12'd0,   12'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[12] = '{4800, 12'd0,   12'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[13] = '{5456, 12'd656, 12'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[14] = '{5600, 12'd0,   12'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[15] = '{7999, 12'd799, 12'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[16] = '{8000, 12'd0,   12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[17] = '{8001, 12'd1,   12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        clr = 1'b1; pix_ce = 1'b1; cfg_wr = 1'b0;
        cfg_h_act = '0; cfg_h_fp = '0; cfg_h_syn = '0; cfg_h_bp = '0;
        cfg_v_act = '0; cfg_v_fp = '0; cfg_v_syn = '0; cfg_v_bp = '0;
        cfg_hpol = 1'b0; cfg_vpol = 1'b0;

        // Reset state
        step(2);
        chk_out("reset_out", 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_pe("reset_cfg", 1'b0, 1'b0);
        chk("reset_fcnt", frame_cnt, 16'd0);
        clr = 1'b0;
        cur = -1;

        // Default raster table
        foreach (vt[i]) begin
            goto(vt[i].pos);
            chk_out($sformatf("vec%0d_p%0d", i, vt[i].pos), vt[i].hc, vt[i].vc,
                    vt[i].hs, vt[i].vs, vt[i].vid, vt[i].ls, vt[i].fs);
        end

        // pix_ce alternating: counters hold on idle cycles, line period doubles
        do_clr();
        bad = 0; en_cnt = 0; prev_hc = '0;
        for (int i = 0; i < 3202; i++) begin
            pix_ce = (i % 2 == 0);
            step(1);
            if (pix_ce) begin
                e_hc = 12'(en_cnt % 800);
                e_vc = 12'(en_cnt / 800);
                if (hc !== e_hc || vc !== e_vc || line_start !== (e_hc == 12'd0)) bad++;
                en_cnt++;
            end else begin
                if (hc !== prev_hc || line_start !== 1'b0 || frame_start !== 1'b0) bad++;
            end
            prev_hc = hc;
            if (line_start) ls_t.push_back(i);
        end
        chk("ce_seq_errs", bad, 0);
        chk("ce_ls_count", ls_t.size(), 3);
        if (ls_t.size() >= 3) begin
            chk("ce_line_period", ls_t[1] - ls_t[0], 1600);
            chk("ce_line_period2", ls_t[2] - ls_t[1], 1600);
        end
        pix_ce = 1'b1;

        // Mid-frame write: current frame completes at full size
        do_clr();
        goto(2000);
        wr(12'd320, 12'd8, 12'd48, 12'd24, 12'd4, 12'd1, 12'd1, 12'd2, 1'b0, 1'b0);
        chk_pe("mid_wr", 1'b1, 1'b0);
        goto(7998);
        chk_out("old_frame_7998", 12'd798, 12'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_pe("pend_7998", 1'b1, 1'b0);
        goto(7999);
        chk_out("old_frame_end", 12'd799, 12'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_pe("pend_cleared", 1'b0, 1'b0);
        goto(8000); chk_out("new_f_start", 12'd0,   12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        goto(8327); chk_out("new_hs_pre",  12'd327, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(8328); chk_out("new_hs_beg",  12'd328, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(8375); chk_out("new_hs_last", 12'd375, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(8376); chk_out("new_hs_end",  12'd376, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(8400); chk_out("new_line1",   12'd0,   12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Accept/reject rules; rejected writes leave staging and timing alone
        wr(12'd20, 12'd2, 12'd3, 12'd5, 12'd6, 12'd1, 12'd2, 12'd3, 1'b1, 1'b0);
        chk_pe("wr_a", 1'b1, 1'b0);
        wr(12'd20, 12'd2, 12'd0, 12'd5, 12'd6, 12'd1, 12'd2, 12'd3, 1'b1, 1'b0);
        chk_pe("wr_hsyn0", 1'b1, 1'b1);
        wr(12'd4000, 12'd32, 12'd32, 12'd33, 12'd6, 12'd1, 12'd2, 12'd3, 1'b1, 1'b0);
        chk_pe("wr_h4097", 1'b1, 1'b1);
        wr(12'd4000, 12'd32, 12'd32, 12'd32, 12'd6, 12'd1, 12'd2, 12'd3, 1'b1, 1'b0);
        chk_pe("wr_h4096", 1'b1, 1'b0);
        wr(12'd20, 12'd2, 12'd3, 12'd5, 12'd6, 12'd1, 12'd2, 12'd3, 1'b1, 1'b0);
        chk_pe("wr_a2", 1'b1, 1'b0);
        wr(12'd20, 12'd2, 12'd3, 12'd5, 12'd4000, 12'd32, 12'd32, 12'd33, 1'b1, 1'b0);
        chk_pe("wr_v4097", 1'b1, 1'b1);
        goto(8800);  chk_out("unchg_line2", 12'd0,   12'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        goto(10000); chk_out("unchg_vs",    12'd0,   12'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        goto(11199); chk_out("f2_end",      12'd399, 12'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_pe("f2_apply_err_sticky", 1'b0, 1'b1);

        // Frame A: 20/2/3/5 x 6/1/2/3, hsync active-high
        goto(11200); chk_out("a_start",  12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        goto(11220); chk_out("a_h20",    12'd20, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(11221); chk_out("a_h21",    12'd21, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(11222); chk_out("a_h22",    12'd22, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(11224); chk_out("a_h24",    12'd24, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(11225); chk_out("a_h25",    12'd25, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(11230); chk_out("a_line1",  12'd0,  12'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        wr(12'd10, 12'd2, 12'd2, 12'd2, 12'd3, 12'd1, 12'd1, 12'd1, 1'b0, 1'b0);
        chk_pe("wr_b", 1'b1, 1'b0);
        goto(11380); chk_out("a_line6",  12'd0,  12'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        goto(11410); chk_out("a_line7",  12'd0,  12'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Write C exactly on the frame-end cycle: B applies now, C one frame later
        goto(11558);
        wr(12'd8, 12'd1, 12'd2, 12'd1, 12'd2, 12'd1, 12'd1, 12'd1, 1'b1, 1'b1);
        chk_out("a_end", 12'd29, 12'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_pe("wr_c_at_end", 1'b1, 1'b0);
        goto(11560); chk_out("b_start", 12'd0,  12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        goto(11575); chk_out("b_h15",   12'd15, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(11576); chk_out("b_line1", 12'd0,  12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        goto(11624); chk_out("b_line4", 12'd0,  12'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        goto(11655); chk_out("b_end",   12'd15, 12'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_pe("b_end_pend", 1'b0, 1'b0);
        goto(11656); chk_out("c_start", 12'd0,  12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(11665); chk_out("c_h9",    12'd9,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        goto(11668); chk_out("c_line1", 12'd0,  12'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        goto(11692); chk_out("c_line3", 12'd0,  12'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        goto(11715); chk_out("c_end",   12'd11, 12'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        goto(11716); chk_out("c_next",  12'd0,  12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // clr mid-frame discards the staged config and restores defaults
        wr(12'd10, 12'd2, 12'd2, 12'd2, 12'd3, 12'd1, 12'd1, 12'd1, 1'b0, 1'b0);
        chk_pe("wr_b2", 1'b1, 1'b0);
        do_clr();
        chk_out("clr_out", 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_pe("clr_cfg", 1'b0, 1'b0);
        goto(0);   chk_out("clr_p0",   12'd0,   12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        goto(656); chk_out("clr_p656", 12'd656, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        goto(800); chk_out("clr_p800", 12'd0,   12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

`ifdef VGA_FRAME_CNT_EN
        chk("fcnt_one_frame", frame_cnt, 16'd1);
`else
        chk("fcnt_zero", frame_cnt, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
